jam_cost_server: RTL and testbench
==================================

Name: jam_cost_server

Overview:
- Responder end of the JAM cost interface.
- Holds the 8x8 worker/job cost matrix, loaded once as a 64-entry stream.
- Answers every (W,J) query with Cost, registered one cycle later.
- An optional result latch captures the solver's final MinCost/MatchCount when Valid pulses.

Parameters:
- N, 8, workers = jobs; W/J index width is clog2(N) = 3.
- COST_W, 7, width of one cost entry.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Restart  input  1  sync pulse; return to IDLE, reload pointer to 0.
- LoadEn  input  1  LoadData valid this cycle.
- LoadData  input  7  cost entry, row-major, index = {W,J}.
- W  input  3  worker index from solver.
- J  input  3  job index from solver.
- Cost  output  7  registered cost of table[{W,J}].
- Ready  output  1  table fully loaded, serving.
- LoadErr  output  1  one-cycle pulse: LoadEn seen while in SERVE.

Behaviour:
- Reset values: Cost=0, Ready=0, LoadErr=0, load pointer=0, state=IDLE. Table storage is not reset.
- States: IDLE, LOAD, SERVE.
- IDLE: LoadEn=1 writes entry 0, pointer->1, go to LOAD.
- LOAD: each LoadEn=1 writes table[ptr] and increments ptr (6-bit). LoadEn=0 stalls; ptr holds, no timeout.
- LOAD -> SERVE: on the write of entry 63, at the same edge. Ready=1 from the following cycle.
- SERVE: every posedge, Cost <= table[{W,J}]. Latency is exactly 1 cycle from W/J sample to Cost. The solver adds Cost two cycles after issuing J=0, so no extra pipeline stage is allowed.
- SERVE with LoadEn=1: table unchanged; LoadErr=1 for exactly that next cycle.
- Cost is held at 0 whenever Ready=0, so undefined storage is never exposed.
- Restart=1 in any state: state->IDLE, ptr->0, Ready->0, Cost->0 next cycle; table contents kept. Restart has priority over a simultaneous LoadEn; that write is dropped.
- Reset mid-LOAD: partial load is discarded; a full 64-entry reload is required.
- No arithmetic besides the pointer increment; ptr wrap 63->0 coincides with the SERVE transition.

Optional Feature:
- Macro: JAM_RESULT_LATCH_EN.
- Defined, extra ports are added:
  - Inputs: Valid(1), MinCost(10), MatchCount(4).
  - Outputs: Done(1), ResultMin(10), ResultCount(4).
- First cycle Valid=1 while Ready=1: ResultMin/ResultCount capture the inputs, Done=1 sticky.
- Later Valid pulses are ignored until Restart or RST, which clear Done and both results to 0.
- Valid while Ready=0 is ignored.
- Undefined: none of these ports exist; core behaviour is identical.

Decomposition:
- Package jam_pkg holds:
  - constants N=8, IDX_W=3, COST_W=7, N_ENTRY=64;
  - the state enum {IDLE, LOAD, SERVE}.
- Natural sub-module: jam_cost_table.
  - 64x7 register array.
  - One write port: we, waddr[5:0], wdata.
  - One registered read port: raddr[5:0] -> rdata.
- Top holds the FSM, pointer, Ready/LoadErr and the optional latch.

Test Plan:
- Load entries k = k mod 100 with LoadEn held 64 cycles -> Ready=0 through the 64th write, Ready=1 the cycle after.
- After load, drive W=3,J=5 -> Cost=29 (index 29) exactly one cycle later. Then W=7,J=7 -> Cost=63.
- LoadEn toggled 1/0 during load (128 cycles) -> ptr advances only on LoadEn=1; Ready rises after the 64th accepted write.
- In SERVE, LoadEn=1 with LoadData=0x7F -> LoadErr pulses 1 cycle; reading {W,J}=0 still returns 0.
- Restart mid-LOAD at ptr=20, then a full reload of all 0x11 -> any query returns 0x11. Also assert RST mid-LOAD -> Ready=0 and Cost=0 immediately.
- JAM_RESULT_LATCH_EN: in SERVE pulse Valid with MinCost=345, MatchCount=3 -> ResultMin=345, ResultCount=3, Done=1. A second Valid with MinCost=1 leaves the results unchanged.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the JAM cost server.
// Optional result latch: define JAM_RESULT_LATCH_EN to add the solver result ports.
package jam_pkg;

    // Matrix geometry: N workers by N jobs, one COST_W-bit cost per cell.
    localparam int N       = 8;
    localparam int IDX_W   = 3;
    localparam int COST_W  = 7;
    localparam int N_ENTRY = N * N;
    localparam int PTR_W   = 2 * IDX_W;

    // Widths of the solver result that the optional latch captures.
    localparam int MIN_W   = 10;
    localparam int CNT_W   = 4;

    // The last load-pointer value; writing it completes the table.
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ENTRY - 1);

    // Server states: waiting for the first entry, streaming entries in, answering queries.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } jam_state_e;

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost storage: one write port and one registered read port.
// The storage cells are deliberately not reset; only the read register is,
// so the server can force Cost to zero while the contents are undefined.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    input  logic              rd_clr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] mem [N_ENTRY];

    // Write port: one entry per cycle while the loader asserts we.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: single register stage, cleared when the caller is not serving.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jam_cost_server.sv
// Responder end of the JAM cost interface.
// Loads an 8x8 worker/job cost matrix as a 64-entry row-major stream, then
// answers every (W,J) query with the registered cost one cycle later.
// Optional feature macro: JAM_RESULT_LATCH_EN adds a one-shot latch for the
// solver's final MinCost/MatchCount.
//
// Interface contract: the loader presents LoadData with LoadEn=1 in any cycle
// it has an entry; there is no back-pressure, and LoadEn=0 simply pauses the
// stream. Ready=1 means all 64 entries are in place and every cycle's {W,J}
// is answered on Cost in the following cycle. LoadEn while Ready=1 is a
// protocol error reported on LoadErr and otherwise ignored.
module jam_cost_server
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Restart,
    input  logic              LoadEn,
    input  logic [COST_W-1:0] LoadData,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              Ready,
    output logic              LoadErr
`ifdef JAM_RESULT_LATCH_EN
    ,
    input  logic              Valid,
    input  logic [MIN_W-1:0]  MinCost,
    input  logic [CNT_W-1:0]  MatchCount,
    output logic              Done,
    output logic [MIN_W-1:0]  ResultMin,
    output logic [CNT_W-1:0]  ResultCount
`endif
);

    // state_q is the FSM state register; it is the signal to observe for
    // state-level checks.
    jam_state_e       state_q;
    jam_state_e       state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             tbl_we;
    logic             err_d;
    logic             rd_clr;

    // State and load-pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: Restart wins over everything, including a same-cycle
    // LoadEn, whose write is dropped. The pointer wraps 63->0 exactly when the
    // final entry moves the FSM into SERVE, so IDLE always starts from 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tbl_we  = 1'b0;
        err_d   = 1'b0;
        if (Restart) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LoadEn) begin
                        tbl_we  = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (LoadEn) begin
                        tbl_we = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                        if (ptr_q == LAST_PTR) begin
                            state_d = SERVE;
                        end
                    end
                end
                SERVE: begin
                    err_d = LoadEn;
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // LoadErr is a registered one-cycle pulse following an illegal load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LoadErr <= 1'b0;
        end else begin
            LoadErr <= err_d;
        end
    end

    // Ready mirrors the SERVE state register directly, so it rises the cycle
    // after entry 63 is written and drops the cycle after Restart.
    assign Ready = (state_q == SERVE);

    // The read register only samples table contents on an edge taken in SERVE
    // without Restart; otherwise it is cleared, keeping Cost at 0 whenever
    // Ready is 0 and never exposing unwritten storage.
    assign rd_clr = Restart || (state_q != SERVE);

    jam_cost_table u_table (
        .CLK    (CLK),
        .RST    (RST),
        .we     (tbl_we),
        .waddr  (ptr_q),
        .wdata  (LoadData),
        .raddr  ({W, J}),
        .rd_clr (rd_clr),
        .rdata  (Cost)
    );

`ifdef JAM_RESULT_LATCH_EN
    // One-shot capture of the solver result; only the first Valid while
    // serving is kept, until Restart or reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Done        <= 1'b0;
            ResultMin   <= '0;
            ResultCount <= '0;
        end else if (Restart) begin
            Done        <= 1'b0;
            ResultMin   <= '0;
            ResultCount <= '0;
        end else if (Valid && Ready && !Done) begin
            Done        <= 1'b1;
            ResultMin   <= MinCost;
            ResultCount <= MatchCount;
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server.
// Stimulus is driven one cycle at a time; a reference model derived from the
// loading/serving rules pushes the expected next-cycle Cost/Ready/LoadErr into
// exp_q, and an independent monitor pops and compares them.
module tb_jam_cost_server;
    import jam_pkg::*;

    // Clock / reset
    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              Restart = 1'b0;
    logic              LoadEn = 1'b0;
    logic [COST_W-1:0] LoadData = '0;
    logic [IDX_W-1:0]  W = '0;
    logic [IDX_W-1:0]  J = '0;
    logic [COST_W-1:0] Cost;
    logic              Ready;
    logic              LoadErr;
`ifdef JAM_RESULT_LATCH_EN
    logic              Valid = 1'b0;
    logic [MIN_W-1:0]  MinCost = '0;
    logic [CNT_W-1:0]  MatchCount = '0;
    logic              Done;
    logic [MIN_W-1:0]  ResultMin;
    logic [CNT_W-1:0]  ResultCount;
`endif

    always #5 CLK = ~CLK;

    jam_cost_server dut (
        .CLK         (CLK),
        .RST         (RST),
        .Restart     (Restart),
        .LoadEn      (LoadEn),
        .LoadData    (LoadData),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .Ready       (Ready),
        .LoadErr     (LoadErr)
`ifdef JAM_RESULT_LATCH_EN
        ,
        .Valid       (Valid),
        .MinCost     (MinCost),
        .MatchCount  (MatchCount),
        .Done        (Done),
        .ResultMin   (ResultMin),
        .ResultCount (ResultCount)
`endif
    );

    // Scoreboard
    typedef struct {
        int         due;
        int         kind;   // 0 Cost, 1 Ready, 2 LoadErr
        logic [9:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [9:0] val);
        exp_q.push_back('{due: cyc + 1, kind: kind, val: val});
    endtask

    // Monitor: checks every expectation that falls due in this cycle.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                0:       chk("cost",    10'(Cost),    mon_e.val);
                1:       chk("ready",   10'(Ready),   mon_e.val);
                default: chk("loaderr", 10'(LoadErr), mon_e.val);
            endcase
        end
    end

    // Reference model: the table as a plain array plus a count of accepted
    // entries. Serving begins once 64 entries have been accepted.
    logic [COST_W-1:0] m_table [64];
    int                m_count = 0;
    bit                m_ready = 0;

    // Driver: apply one cycle of inputs, predict the next cycle, advance.
    task automatic step(input bit rs, input bit le, input logic [COST_W-1:0] d,
                        input logic [IDX_W-1:0] w, input logic [IDX_W-1:0] j);
        Restart  = rs;
        LoadEn   = le;
        LoadData = d;
        W        = w;
        J        = j;
        if (rs) begin
            m_count = 0;
            m_ready = 0;
            push(0, 0);
            push(1, 0);
            push(2, 0);
        end else if (m_ready) begin
            push(0, 10'(m_table[int'(w) * 8 + int'(j)]));
            push(1, 1);
            push(2, 10'(le));
        end else begin
            push(0, 0);
            push(2, 0);
            if (le) begin
                m_table[m_count] = d;
                m_count++;
            end
            if (m_count == 64) m_ready = 1;
            push(1, 10'(m_ready));
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [COST_W-1:0] rnd_c();
        return COST_W'($urandom_range(0, 127));
    endfunction

    function automatic logic [IDX_W-1:0] rnd_i();
        return IDX_W'($urandom_range(0, 7));
    endfunction

    task automatic random_queries(input int n);
        for (int i = 0; i < n; i++) step(0, 0, rnd_c(), rnd_i(), rnd_i());
    endtask

    task automatic full_load_random();
        for (int i = 0; i < 64; i++) step(0, 1, rnd_c(), rnd_i(), rnd_i());
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        #2;
        chk("reset_ready",   10'(Ready),   0);
        chk("reset_cost",    10'(Cost),    0);
        chk("reset_loaderr", 10'(LoadErr), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Load k mod 100 with LoadEn held for 64 cycles.
        for (int k = 0; k < 64; k++) step(0, 1, COST_W'(k % 100), rnd_i(), rnd_i());
        // Directed queries: {3,5} -> 29, {7,7} -> 63.
        step(0, 0, '0, 3'd3, 3'd5);
        step(0, 0, '0, 3'd7, 3'd7);
        random_queries(12);

        // Illegal load while serving; entry 0 must keep its value.
        step(0, 1, 7'h7F, 3'd0, 3'd0);
        step(0, 0, '0, 3'd0, 3'd0);
        step(0, 0, '0, 3'd0, 3'd0);

        // Restart, then a load with LoadEn toggled over 128 cycles.
        step(1, 0, '0, rnd_i(), rnd_i());
        for (int i = 0; i < 128; i++) step(0, (i % 2) == 0, rnd_c(), rnd_i(), rnd_i());
        random_queries(12);

        // Restart mid-load at pointer 20, then a full reload of 0x11.
        step(1, 0, '0, rnd_i(), rnd_i());
        for (int i = 0; i < 20; i++) step(0, 1, rnd_c(), rnd_i(), rnd_i());
        step(1, 1, 7'h55, rnd_i(), rnd_i());
        for (int i = 0; i < 64; i++) step(0, 1, 7'h11, rnd_i(), rnd_i());
        random_queries(10);

        // Asynchronous reset mid-load: outputs drop without waiting for a clock.
        step(1, 0, '0, rnd_i(), rnd_i());
        for (int i = 0; i < 30; i++) step(0, 1, rnd_c(), rnd_i(), rnd_i());
        @(negedge CLK);
        #1;
        exp_q.delete();
        RST = 1'b1;
        #1;
        chk("rst_load_ready", 10'(Ready), 0);
        chk("rst_load_cost",  10'(Cost),  0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_count = 0;
        m_ready = 0;
        full_load_random();
        random_queries(6);

        // Asynchronous reset while serving a known nonzero cost.
        m_table[9] = 7'h5A;
        step(1, 0, '0, 3'd0, 3'd0);
        for (int i = 0; i < 64; i++) step(0, 1, (i == 9) ? 7'h5A : rnd_c(), rnd_i(), rnd_i());
        step(0, 0, '0, 3'd1, 3'd1);
        @(negedge CLK);
        #1;
        chk("serve_cost_before_rst", 10'(Cost), 10'h5A);
        exp_q.delete();
        RST = 1'b1;
        #1;
        chk("rst_serve_ready", 10'(Cready_fix()), 0);
        chk("rst_serve_cost",  10'(Cost),  0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_count = 0;
        m_ready = 0;

        // Mixed random traffic, including stray loads and rare restarts.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rnd_c(), rnd_i(), rnd_i());
        end

`ifdef JAM_RESULT_LATCH_EN
        step(1, 0, '0, '0, '0);
        full_load_random();
        Valid = 1'b1;
        MinCost = 10'd345;
        MatchCount = 4'd3;
        step(0, 0, '0, '0, '0);
        Valid = 1'b0;
        chk("latch_done",  10'(Done),        1);
        chk("latch_min",   ResultMin,        10'd345);
        chk("latch_count", 10'(ResultCount), 3);
        Valid = 1'b1;
        MinCost = 10'd1;
        MatchCount = 4'd9;
        step(0, 0, '0, '0, '0);
        Valid = 1'b0;
        chk("latch_hold_min",   ResultMin,        10'd345);
        chk("latch_hold_count", 10'(ResultCount), 3);
        step(1, 0, '0, '0, '0);
        chk("latch_clear_done", 10'(Done), 0);
        Valid = 1'b1;
        step(0, 0, '0, '0, '0);
        Valid = 1'b0;
        chk("latch_notready_done", 10'(Done), 0);
`endif

        step(0, 0, '0, '0, '0);
        @(negedge CLK);
        #1;
        chk("queue_drained", 10'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic Cready_fix();
        return Ready;
    endfunction

endmodule
